// File: rtl/sseg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block: FSM states,
// glyph patterns, character codes and anode digit-select values.
package sseg_scan_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam logic [3:0] ANODE_D3    = 4'b0111;
    localparam logic [3:0] ANODE_D2    = 4'b1011;
    localparam logic [3:0] ANODE_D1    = 4'b1101;
    localparam logic [3:0] ANODE_D0    = 4'b1110;
    localparam logic [3:0] ANODE_BLANK = 4'b1111;

    // Active-low glyphs, dp (bit 7) off; bits 6:0 are segments g..a
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_A    = 8'h88;
    localparam logic [7:0] SEG_D    = 8'hA1;
    localparam logic [7:0] SEG_G    = 8'hC2;
    localparam logic [7:0] SEG_L    = 8'hC7;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_P    = 8'h8C;
    localparam logic [7:0] SEG_R    = 8'hAF;
    localparam logic [7:0] SEG_U    = 8'hC1;

    localparam logic [4:0] CODE_A       = 5'd10;
    localparam logic [4:0] CODE_D       = 5'd13;
    localparam logic [4:0] CODE_G       = 5'd16;
    localparam logic [4:0] CODE_L       = 5'd21;
    localparam logic [4:0] CODE_DASH    = 5'd22;
    localparam logic [4:0] CODE_P       = 5'd25;
    localparam logic [4:0] CODE_R       = 5'd27;
    localparam logic [4:0] CODE_U       = 5'd29;
    localparam logic [4:0] UNKNOWN_CODE = 5'd31;

    // Character ROM as parallel tables; index 0 holds the '0' glyph
    localparam int NUM_GLYPHS = 18;
    localparam logic [NUM_GLYPHS-1:0][7:0] GLYPH_PAT = {
        SEG_U, SEG_R, SEG_P, SEG_DASH, SEG_L, SEG_G, SEG_D, SEG_A,
        SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };
    localparam logic [NUM_GLYPHS-1:0][4:0] GLYPH_CODE = {
        CODE_U, CODE_R, CODE_P, CODE_DASH, CODE_L, CODE_G, CODE_D, CODE_A,
        5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0
    };

    function automatic logic anode_onehot(input logic [3:0] a);
        return (a == ANODE_D3) || (a == ANODE_D2) || (a == ANODE_D1) || (a == ANODE_D0);
    endfunction

    function automatic logic [1:0] anode_slot(input logic [3:0] a);
        logic [1:0] s;
        s = 2'd0;
        case (a)
            ANODE_D3: s = 2'd3;
            ANODE_D2: s = 2'd2;
            ANODE_D1: s = 2'd1;
            default:  s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_capture_char_decode.sv
// Inverse character ROM: maps a segment pattern (dp ignored) back to its code.
module sseg_char_decode
    import sseg_scan_capture_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [4:0] code,
    output logic       unknown
);

    always_comb begin
        code    = UNKNOWN_CODE;
        unknown = 1'b1;
        // Forcing bit 7 high on both sides makes the dp state irrelevant
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if ((pattern | 8'h80) == (GLYPH_PAT[i] | 8'h80)) begin
                code    = GLYPH_CODE[i];
                unknown = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Recovers displayed characters by sampling a multiplexed seven-segment scan:
// each digit is latched once its anode has been stable, four digits form a frame.
module sseg_scan_capture
    import sseg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1 << 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode,
    input  logic [7:0]  sseg,
    output logic [31:0] frame,
    output logic [19:0] codes,
    output logic [3:0]  unknown,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        glitch
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = $clog2(FRAME_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        sel_q, sel_d;
    logic [3:0][7:0]   slots_q, slots_d;
    logic [3:0]        captured_q, captured_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [31:0]       frame_q, frame_d;
    logic              valid_q, valid_d;
    logic              changed_q, changed_d;
    logic              glitch_q, glitch_d;
    logic              first_q, first_d;
    logic [3:0]        prev_q, prev_d;
    logic              cap_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cap_en  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (anode_onehot(anode)) begin
                    sel_d = anode;
                    if (SETTLE_CYCLES <= 1) begin
                        cap_en  = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (anode != sel_q) begin
                    if (anode_onehot(anode)) begin
                        sel_d = anode;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q + CNT_W'(1) == CNT_W'(SETTLE_CYCLES)) begin
                    cap_en  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (anode != sel_q) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Frame assembly: completion is applied before a same-cycle capture so
    // that capture becomes the first digit of the next frame.
    always_comb begin
        slots_d    = slots_q;
        captured_d = captured_q;
        timer_d    = timer_q;
        frame_d    = frame_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        first_d    = first_q;
        if (&captured_q) begin
            frame_d    = slots_q;
            valid_d    = 1'b1;
            changed_d  = first_q || (slots_q != frame_q);
            first_d    = 1'b0;
            captured_d = '0;
            timer_d    = '0;
        end else if (|captured_q) begin
            if (timer_q == TMR_W'(FRAME_TIMEOUT - 1)) begin
                captured_d = '0;
                timer_d    = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
        if (cap_en) begin
            slots_d[anode_slot(anode)]    = sseg;
            captured_d[anode_slot(anode)] = 1'b1;
        end
        prev_d   = anode;
        glitch_d = !anode_onehot(anode) && (anode != ANODE_BLANK) && (anode != prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            sel_q      <= ANODE_BLANK;
            slots_q    <= '1;
            captured_q <= '0;
            timer_q    <= '0;
            frame_q    <= 32'hFFFF_FFFF;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            glitch_q   <= 1'b0;
            first_q    <= 1'b1;
            prev_q     <= ANODE_BLANK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            slots_q    <= slots_d;
            captured_q <= captured_d;
            timer_q    <= timer_d;
            frame_q    <= frame_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            glitch_q   <= glitch_d;
            first_q    <= first_d;
            prev_q     <= prev_d;
        end
    end

    for (genvar d = 0; d < 4; d++) begin : g_dec
        sseg_char_decode u_dec (
            .pattern (frame_q[d*8 +: 8]),
            .code    (codes[d*5 +: 5]),
            .unknown (unknown[d])
        );
    end

    assign frame         = frame_q;
    assign frame_valid   = valid_q;
    assign frame_changed = changed_q;
    assign glitch        = glitch_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed scans of a multiplexed display; expected frames are queued by the
// driver and consumed by a monitor on each frame_valid pulse.
module tb_sseg_scan_capture;

    localparam int SC = 4;
    localparam int FT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode;
    logic [7:0]  sseg;
    logic [31:0] frame;
    logic [19:0] codes;
    logic [3:0]  unknown;
    logic        frame_valid;
    logic        frame_changed;
    logic        glitch;

    // {changed, unknown, codes, frame}
    logic [56:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          glitch_seen = 0;

    sseg_scan_capture #(.SETTLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
        .clk           (clk),
        .rst           (rst),
        .anode         (anode),
        .sseg          (sseg),
        .frame         (frame),
        .codes         (codes),
        .unknown       (unknown),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .glitch        (glitch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pack_codes(input logic [4:0] c3, input logic [4:0] c2,
                                               input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic expect_frame(input logic [31:0] f, input logic [19:0] c,
                                input logic [3:0] u, input logic ch);
        exp_q.push_back({ch, u, c, f});
    endtask

    // Called at a negedge; holds the values for n rising edges.
    task automatic show(input logic [3:0] a, input logic [7:0] s, input int n);
        anode = a;
        sseg  = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] b3, input logic [7:0] b2,
                        input logic [7:0] b1, input logic [7:0] b0, input int n);
        show(4'b0111, b3, n);
        show(4'b1011, b2, n);
        show(4'b1101, b1, n);
        show(4'b1110, b0, n);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_frame"}, frame, 32'hFFFF_FFFF);
        chk({tag, "_codes"}, {12'h0, codes}, 32'h000F_FFFF);
        chk({tag, "_unknown"}, {28'h0, unknown}, 32'hF);
        chk({tag, "_valid"}, {31'h0, frame_valid}, 32'h0);
        chk({tag, "_changed"}, {31'h0, frame_changed}, 32'h0);
        chk({tag, "_glitch"}, {31'h0, glitch}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (glitch) glitch_seen++;
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_frame_valid: got frame %h expected no frame", frame);
                end else begin
                    logic [56:0] e;
                    e = exp_q.pop_front();
                    chk("frame", frame, e[31:0]);
                    chk("codes", {12'h0, codes}, {12'h0, e[51:32]});
                    chk("unknown", {28'h0, unknown}, {28'h0, e[55:52]});
                    chk("frame_changed", {31'h0, frame_changed}, {31'h0, e[56]});
                end
            end
        end
    end

    initial begin
        int g0;
        rst   = 1'b1;
        anode = 4'hF;
        sseg  = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Basic scan, then identical repeat
        expect_frame(32'hC0F9A4B0, pack_codes(5'd0, 5'd1, 5'd2, 5'd3), 4'h0, 1'b1);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
        show(4'hF, 8'hFF, 5);
        expect_frame(32'hC0F9A4B0, pack_codes(5'd0, 5'd1, 5'd2, 5'd3), 4'h0, 1'b0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
        show(4'hF, 8'hFF, 5);

        // Too-short holds: nothing captured
        scan(8'h99, 8'h92, 8'h82, 8'hF8, 3);
        show(4'hF, 8'hFF, 20);

        // Glitch pattern replaces digit 1; next good scan completes at digit 1
        g0 = glitch_seen;
        show(4'b0111, 8'hC0, 10);
        show(4'b1011, 8'hF9, 10);
        show(4'b0011, 8'hA4, 10);
        show(4'b1110, 8'hB0, 10);
        expect_frame(32'h999282B0, pack_codes(5'd4, 5'd5, 5'd6, 5'd3), 4'h0, 1'b1);
        show(4'b0111, 8'h99, 10);
        show(4'b1011, 8'h92, 10);
        show(4'b1101, 8'h82, 10);
        show(4'hF, 8'hFF, 5);
        chk("glitch_once", glitch_seen, g0 + 1);
        show(4'b1110, 8'hF8, 10);
        show(4'hF, 8'hFF, FT + 50);

        // Timeout discards three digits; a lone digit afterwards is not enough
        show(4'b0111, 8'h80, 10);
        show(4'b1011, 8'h90, 10);
        show(4'b1101, 8'h88, 10);
        show(4'hF, 8'hFF, FT + 50);
        show(4'b0111, 8'h80, 10);
        show(4'hF, 8'hFF, 20);
        expect_frame(32'h88A1C2C7, pack_codes(5'd10, 5'd13, 5'd16, 5'd21), 4'h0, 1'b1);
        scan(8'h88, 8'hA1, 8'hC2, 8'hC7, 10);
        show(4'hF, 8'hFF, 5);

        // dp ignored on 'U', unmatched FF on digit 1
        expect_frame(32'h418CFFAF, pack_codes(5'd29, 5'd25, 5'd31, 5'd27), 4'b0010, 1'b1);
        scan(8'h41, 8'h8C, 8'hFF, 8'hAF, 10);
        show(4'hF, 8'hFF, 5);
        expect_frame(32'hBFC0C0C0, pack_codes(5'd22, 5'd0, 5'd0, 5'd0), 4'h0, 1'b1);
        scan(8'hBF, 8'hC0, 8'hC0, 8'hC0, 10);
        show(4'hF, 8'hFF, 5);

        // Reset mid-frame: earlier digits must not count afterwards
        show(4'b0111, 8'hC0, 10);
        show(4'b1011, 8'hF9, 10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        show(4'b1101, 8'hA4, 10);
        show(4'b1110, 8'hB0, 10);
        show(4'hF, 8'hFF, FT + 50);

        // First frame after reset reports a change even if equal to reset value
        expect_frame(32'hFFFFFFFF, 20'hFFFFF, 4'hF, 1'b1);
        scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 10);
        show(4'hF, 8'hFF, 10);

        chk("pending_expected", exp_q.size(), 0);
        chk("glitch_total", glitch_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
